// File: rtl/uart_rx_word_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_assembler_if
// Brief    : Word handshake bundle between the UART word assembler and its
//            consumer. The assembler is the master: it drives word_data and
//            word_valid and observes word_ready.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_word_assembler_if #(
   parameter int BIT_WIDTH = 32
) ();

   logic [BIT_WIDTH-1:0] word_data;
   logic                 word_valid;
   logic                 word_ready;

   modport master (
      output word_data,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_valid,
      output word_ready
   );

endinterface : uart_rx_word_assembler_if
`default_nettype wire

// File: rtl/uart_rx_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_assembler
// Brief    : Packs BYTES consecutive UART bytes, MSB first, into one BIT_WIDTH
//            word and offers it over a valid/ready handshake. The byte strobe
//            is synchronized from the UART clock domain and edge-detected. An
//            inter-byte timeout discards partial words; overrun and framing
//            errors are sticky until cleared.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_assembler #(
   parameter int BIT_WIDTH      = 32,
   parameter int BYTES          = BIT_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int CNT_WIDTH      = $clog2(BYTES + 1),
   parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  wire logic                 clk_i,
   input  wire logic                 rst_n_i,
   input  wire logic                 rx_dv_i,
   input  wire logic [7:0]           rx_byte_i,
   input  wire logic                 clr_err_i,
   uart_rx_word_assembler_if.master  word_if,
   output logic      [CNT_WIDTH-1:0] byte_cnt_o,
   output logic                      overrun_o,
   output logic                      frame_err_o
);

   localparam logic [CNT_WIDTH-1:0] BYTES_C   = CNT_WIDTH'(BYTES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [TO_WIDTH-1:0]  TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_WIDTH-1:0]  TO_ONE    = TO_WIDTH'(1);
   localparam bit                   ONE_BYTE  = (BYTES == 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registers and next-state values
   // ------------------------------------------------------------------------
   state_t                 state_q,   state_d;
   logic [BIT_WIDTH-1:0]   shift_q,   shift_d;
   logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
   logic [TO_WIDTH-1:0]    to_q,      to_d;
   logic                   overrun_q, overrun_d;
   logic                   frame_q,   frame_d;
   logic                   s1_q, s2_q, s3_q;

   logic                   byte_strobe;
   logic                   handshake;
   logic [BIT_WIDTH-1:0]   shift_ins;
   logic [CNT_WIDTH-1:0]   cnt_inc;
   logic                   set_overrun;
   logic                   set_frame;

   // One clk pulse per rising edge of the synchronized rx_dv.
   assign byte_strobe = s2_q & ~s3_q;
   assign handshake   = (state_q == ST_HOLD) & word_if.word_ready;
   // Shift left one byte lane and insert the new byte at the LSB.
   assign shift_ins   = (shift_q << 8) | BIT_WIDTH'(rx_byte_i);
   assign cnt_inc     = cnt_q + CNT_ONE;

   // Two-flop synchronizer for rx_dv plus a delay flop for edge detection.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= rx_dv_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // State, data, counter and error-flag registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         to_q      <= '0;
         overrun_q <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         overrun_q <= overrun_d;
         frame_q   <= frame_d;
      end
   end

   // Next-state logic: byte capture, word completion, handshake and timeout.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      to_d        = '0;
      set_overrun = 1'b0;
      set_frame   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (byte_strobe) begin
               shift_d = shift_ins;
               cnt_d   = CNT_ONE;
               state_d = ONE_BYTE ? ST_HOLD : ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (byte_strobe) begin
               // A strobe in the expiry cycle still counts as a good byte.
               shift_d = shift_ins;
               cnt_d   = cnt_inc;
               if (cnt_inc == BYTES_C) begin
                  state_d = ST_HOLD;
               end
            end else if (to_q == TO_LAST) begin
               cnt_d     = '0;
               set_frame = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               to_d = to_q + TO_ONE;
            end
         end

         ST_HOLD: begin
            if (handshake) begin
               if (byte_strobe) begin
                  // The slot frees on this edge, so the byte starts a new word.
                  shift_d = shift_ins;
                  cnt_d   = CNT_ONE;
                  state_d = ONE_BYTE ? ST_HOLD : ST_COLLECT;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end else if (byte_strobe) begin
               // No room: the byte is lost and the held word is untouched.
               set_overrun = 1'b1;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // Sticky flags; a new event in the clear cycle takes priority.
      overrun_d = (overrun_q & ~clr_err_i) | set_overrun;
      frame_d   = (frame_q   & ~clr_err_i) | set_frame;
   end

   assign word_if.word_data  = shift_q;
   assign word_if.word_valid = (state_q == ST_HOLD);
   assign byte_cnt_o         = cnt_q;
   assign overrun_o          = overrun_q;
   assign frame_err_o        = frame_q;

endmodule : uart_rx_word_assembler
`default_nettype wire

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
Receive-side counterpart of the word-to-byte UART serializer. It takes the byte stream from the UART receiver (data-valid strobe plus byte) and packs BYTES consecutive bytes, MSB first, into one BIT_WIDTH word. The word is handed to the MIPS datapath over a valid/ready handshake. The strobe may come from the slower UART clock, so it is synchronized and edge-detected. An inter-byte timeout resynchronizes framing, and overrun and framing errors are flagged.

Parameters:
BIT_WIDTH, 32, output word width; multiple of 8
BYTES, BIT_WIDTH/8, bytes per word
TIMEOUT_CYCLES, 50000, clk cycles without a new byte before a partial word is discarded
CNT_WIDTH, $clog2(BYTES+1), width of byte_cnt
TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of timeout counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rx_dv  input  1  byte-valid from UART receiver; async to clk; a rising edge marks a new byte
rx_byte  input  8  received byte; stable for at least 4 clk cycles after rx_dv rises
word_ready  input  1  consumer accepts word_data when high together with word_valid
clr_err  input  1  synchronous clear of overrun and frame_err
word_data  output  BIT_WIDTH  assembled word
word_valid  output  1  word_data holds a complete word
byte_cnt  output  CNT_WIDTH  bytes collected toward the current word
overrun  output  1  sticky: a byte was dropped while a word was pending
frame_err  output  1  sticky: a partial word was discarded on timeout

Behaviour:
- Reset (rst=0, async): all outputs 0. Sync flops, timeout counter and state are cleared, and state goes to IDLE. Reset mid-word discards the partial data.
- Synchronizer: rx_dv goes through 2 flops (s1, s2) and then a delay flop (s3). byte_strobe = s2 & ~s3, exactly one clk pulse per rx_dv rising edge.
  - rx_byte is sampled on the clk edge where byte_strobe is high, i.e. the 3rd rising clk edge after rx_dv is first sampled high.
- Packing: the first byte of a word goes to word_data[BIT_WIDTH-1 -: 8]; later bytes fill descending byte lanes, and the last byte goes to [7:0]. The shift register shifts left by 8 and inserts at the LSB. byte_cnt increments per accepted byte.
- FSM states:
  - IDLE (byte_cnt=0): on byte_strobe, capture the byte, set byte_cnt=1 and go to COLLECT (when BYTES=1, go directly to HOLD).
  - COLLECT: each byte_strobe captures a byte and increments byte_cnt.
    - When the capture reaches byte_cnt=BYTES, go to HOLD on the same edge: word_valid=1 and byte_cnt=BYTES.
    - If TIMEOUT_CYCLES consecutive cycles pass with no strobe, discard the partial word (byte_cnt=0), set frame_err=1 and go to IDLE.
  - HOLD: word_valid=1 and word_data is stable until handshake.
    - Handshake (word_valid & word_ready): on that edge word_valid becomes 0 and byte_cnt becomes 0, and the FSM goes to IDLE.
    - byte_strobe in HOLD without handshake: the byte is dropped, overrun=1, and word_data is unchanged.
    - byte_strobe on the handshake edge: the byte is accepted as the first byte of the next word (byte_cnt=1, COLLECT), with no overrun.
- Timeout counter: reset to 0 on every byte_strobe and in IDLE/HOLD; it only increments in COLLECT and does not run in HOLD. The expiry check is counter==TIMEOUT_CYCLES-1 with no strobe in that cycle. A strobe arriving in the expiry cycle wins and the byte is accepted.
- Errors: overrun and frame_err are sticky until clr_err=1, which clears them on the next edge. If clr_err and a new error event occur in the same cycle, the set wins.
- word_data between words: holds the last delivered word. During COLLECT it shows the partial shift contents, which are not meaningful.
- Latency: the last byte's rx_dv is sampled high at edge N; word_valid is high after edge N+2.

Test Plan:
- Bytes 0xDE, 0xAD, 0xBE, 0xEF with rx_dv pulses 100 clk apart and word_ready=1 -> word_data=0xDEADBEEF, word_valid high exactly 1 cycle, 3 edges after the 4th rx_dv is sampled; no flags.
- Same four bytes with word_ready=0, then a 5th byte 0x11 -> word_valid held, word_data=0xDEADBEEF, overrun=1. Raise word_ready -> one transfer; clr_err -> overrun=0.
- TIMEOUT_CYCLES=20, bytes 0x01, 0x02, then idle 25 cycles -> frame_err=1, byte_cnt=0. Then bytes 0xA0, 0xA1, 0xA2, 0xA3 -> word_data=0xA0A1A2A3.
- word_ready raised on the same edge as the next word's first byte strobe (0x55) -> transfer completes, byte_cnt=1, overrun=0. Following bytes 0x66, 0x77, 0x88 -> 0x55667788.
- rst=0 asserted after 2 bytes, released, then 4 bytes 0x10, 0x20, 0x30, 0x40 -> outputs 0 during reset; word_data=0x10203040, with no leftover bytes.
- rx_dv held high for 500 cycles -> exactly one byte accepted (byte_cnt=1).
